// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode and immediate-format definitions for the immediate
// generation stage and any decoder that reuses imm_decode.
package imm_gen_stage_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSR   = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out handshake bundle of the immediate stage.
// master is the surrounding pipeline (producer + consumer), slave is the stage.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational RV32/RV64 immediate extractor: instruction word in,
// extended immediate, format code and illegal flag out.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [31:0] raw_i;
  logic signed [31:0] raw_s;
  logic signed [31:0] raw_b;
  logic signed [31:0] raw_j;
  logic signed [31:0] raw_u;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount, not an immediate
  assign is_shift = (funct3[1:0] == 2'b01);

  assign raw_i = {{20{instr[31]}}, instr[31:20]};
  assign raw_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign raw_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign raw_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign raw_u = {instr[31:12], 12'h000};

  // Widen a 32-bit signed immediate to XLEN by replicating bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] w;
    w = XLEN'(v);
    return w;
  endfunction

  // Opcode-driven format select; every illegal path leaves imm=0, fmt=NONE.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        fmt = FMT_I;
        imm = sext32(raw_i);
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = sext32(raw_s);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = sext32(raw_b);
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = sext32(raw_j);
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = sext32(raw_u);
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          // RV32 has only a 5-bit shamt; bit 25 set would mean shamt >= 32
          if (XLEN == 32 && instr[25]) begin
            illegal = 1'b1;
          end else begin
            fmt = FMT_SHAMT;
            imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
          end
        end else begin
          fmt = FMT_I;
          imm = sext32(raw_i);
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          // word shifts are 5-bit even on RV64
          if (instr[25]) begin
            illegal = 1'b1;
          end else begin
            fmt = FMT_SHAMT;
            imm = XLEN'(instr[24:20]);
          end
        end else begin
          fmt = FMT_I;
          imm = sext32(raw_i);
        end
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          fmt = FMT_CSR;
          imm = XLEN'(instr[19:15]);
        end else begin
          fmt = FMT_I;
          imm = sext32(raw_i);
        end
      end
      OPC_OP: begin
        // register-register: legal, no immediate
      end
      OPC_OP_32: begin
        if (XLEN != 64) illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes one instruction per cycle,
// presents the result through a main register backed by one skid entry,
// and keeps a saturating count of illegal instructions handed downstream.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             clr_count,
  imm_gen_stage_if.slave   bus,
  output logic [CNT_W-1:0] illegal_count
);

  // ---- p0: combinational decode of the presented instruction ----
  logic [XLEN-1:0] imm_p0;
  fmt_e            fmt_p0;
  logic            ill_p0;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .imm     (imm_p0),
    .fmt     (fmt_p0),
    .illegal (ill_p0)
  );

  // ---- p1: main output register and skid overflow entry ----
  logic             vld_p1;
  logic [XLEN-1:0]  imm_p1;
  fmt_e             fmt_p1;
  logic             ill_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             sk_vld_p1;
  logic [XLEN-1:0]  sk_imm_p1;
  fmt_e             sk_fmt_p1;
  logic             sk_ill_p1;
  logic [TAG_W-1:0] sk_tag_p1;

  logic             in_ready_w;
  logic             in_fire;
  logic             out_fire;
  logic             main_adv;

  // in_ready comes straight from a flop: accept whenever the skid slot is free
  assign in_ready_w = ~sk_vld_p1;
  assign in_fire    = bus.in_valid & in_ready_w;
  assign out_fire   = vld_p1 & bus.out_ready;
  // main may be overwritten when it is empty or being consumed this cycle
  assign main_adv   = ~vld_p1 | bus.out_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Main register: refill from skid first to preserve order, else from input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      fmt_p1 <= FMT_NONE;
      ill_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (main_adv) begin
      if (sk_vld_p1) begin
        vld_p1 <= 1'b1;
        imm_p1 <= sk_imm_p1;
        fmt_p1 <= sk_fmt_p1;
        ill_p1 <= sk_ill_p1;
        tag_p1 <= sk_tag_p1;
      end else begin
        vld_p1 <= in_fire;
        if (in_fire) begin
          imm_p1 <= imm_p0;
          fmt_p1 <= fmt_p0;
          ill_p1 <= ill_p0;
          tag_p1 <= bus.in_tag;
        end
      end
    end
  end

  // Skid register: catches the one input accepted while main is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk_vld_p1 <= 1'b0;
      sk_imm_p1 <= '0;
      sk_fmt_p1 <= FMT_NONE;
      sk_ill_p1 <= 1'b0;
      sk_tag_p1 <= '0;
    end else if (flush) begin
      sk_vld_p1 <= 1'b0;
    end else if (!main_adv) begin
      if (in_fire) begin
        sk_vld_p1 <= 1'b1;
        sk_imm_p1 <= imm_p0;
        sk_fmt_p1 <= fmt_p0;
        sk_ill_p1 <= ill_p0;
        sk_tag_p1 <= bus.in_tag;
      end
    end else begin
      sk_vld_p1 <= 1'b0;
    end
  end

  // Illegal counter: clear wins over a counted handshake in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (clr_count) begin
      illegal_count <= '0;
    end else if (out_fire && ill_p1) begin
      illegal_count <= sat_inc(illegal_count);
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_fmt     = fmt_p1;
  assign bus.out_illegal = ill_p1;
  assign bus.out_tag     = tag_p1;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: three instances cover RV32, RV64 and a
// narrow 2-bit illegal counter; expected values are hand-derived constants.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic clr_count;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
  logic [1:0]  cnt_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) ifa ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) ifb ();
  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) ifc ();

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(16)) ua (
    .clk(clk), .reset(reset), .flush(flush), .clr_count(clr_count),
    .bus(ifa), .illegal_count(cnt_a)
  );
  imm_gen_stage #(.XLEN(64), .TAG_W(32), .CNT_W(16)) ub (
    .clk(clk), .reset(reset), .flush(flush), .clr_count(clr_count),
    .bus(ifb), .illegal_count(cnt_b)
  );
  imm_gen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(2)) uc (
    .clk(clk), .reset(reset), .flush(flush), .clr_count(clr_count),
    .bus(ifc), .illegal_count(cnt_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [31:0] instr, input logic [31:0] tag);
    ifa.in_valid = v;
    ifa.in_instr = instr;
    ifa.in_tag   = tag;
  endtask

  // Watchdog: no phase below waits on the DUT open-endedly, but guard anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_vec [4];
    int tx, rx, bubbles;
    logic in_f;

    reset = 1'b1; flush = 1'b0; clr_count = 1'b0;
    ifa.in_valid = 0; ifa.in_instr = '0; ifa.in_tag = '0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_instr = '0; ifb.in_tag = '0; ifb.out_ready = 0;
    ifc.in_valid = 0; ifc.in_instr = '0; ifc.in_tag = '0; ifc.out_ready = 0;
    repeat (2) step();

    // reset state
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_imm", ifa.out_imm, 0);
    chk("rst_out_fmt", ifa.out_fmt, 0);
    chk("rst_out_illegal", ifa.out_illegal, 0);
    chk("rst_out_tag", ifa.out_tag, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
    reset = 1'b0;
    step();

    // RV32 decode stream, out_ready held high
    ifa.out_ready = 1'b1;
    drv_a(1, 32'hFFF00093, 32'h100); step();
    chk("addi_valid", ifa.out_valid, 1);
    chk("addi_imm", ifa.out_imm, 32'hFFFFFFFF);
    chk("addi_fmt", ifa.out_fmt, 1);
    chk("addi_tag", ifa.out_tag, 32'h100);
    drv_a(1, 32'hFE000EE3, 32'h104); step();
    chk("beq_imm", ifa.out_imm, 32'hFFFFFFFC);
    chk("beq_fmt", ifa.out_fmt, 3);
    chk("beq_tag", ifa.out_tag, 32'h104);
    drv_a(1, 32'h4030D093, 32'h108); step();
    chk("srai_imm", ifa.out_imm, 3);
    chk("srai_fmt", ifa.out_fmt, 6);
    chk("srai_illegal", ifa.out_illegal, 0);
    drv_a(1, 32'h02009093, 32'h10C); step();
    chk("slli32_illegal", ifa.out_illegal, 1);
    chk("slli32_imm", ifa.out_imm, 0);
    chk("slli32_fmt", ifa.out_fmt, 0);
    chk("slli32_cnt_before", cnt_a, 0);
    drv_a(1, 32'h0030909B, 32'h110); step();
    chk("slliw_rv32_illegal", ifa.out_illegal, 1);
    chk("slli32_cnt_after", cnt_a, 1);
    drv_a(0, 32'h0, 32'h0); step();
    chk("drain_valid", ifa.out_valid, 0);
    chk("slliw_cnt_after", cnt_a, 2);

    // RV64 decode
    ifb.out_ready = 1'b1;
    ifb.in_valid = 1; ifb.in_instr = 32'h80000037; ifb.in_tag = 32'h200; step();
    chk("lui64_valid", ifb.out_valid, 1);
    chk("lui64_imm", ifb.out_imm, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", ifb.out_fmt, 4);
    chk("lui64_tag", ifb.out_tag, 32'h200);
    ifb.in_instr = 32'h02009093; ifb.in_tag = 32'h204; step();
    chk("slli64_imm", ifb.out_imm, 32);
    chk("slli64_fmt", ifb.out_fmt, 6);
    chk("slli64_illegal", ifb.out_illegal, 0);
    ifb.in_instr = 32'h0030909B; ifb.in_tag = 32'h208; step();
    chk("slliw64_imm", ifb.out_imm, 3);
    chk("slliw64_fmt", ifb.out_fmt, 6);
    ifb.in_valid = 0; step();
    chk("rv64_count", cnt_b, 0);

    // 2-bit saturating counter
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1; ifc.in_instr = 32'h0; ifc.in_tag = 32'(i); step();
      chk("zero_word_illegal", ifc.out_illegal, 1);
      ifc.in_valid = 0; step();
      chk("sat_count", cnt_c, (i < 3) ? i + 1 : 3);
    end
    ifc.in_valid = 1; step();
    ifc.in_valid = 0; clr_count = 1'b1; step();
    clr_count = 1'b0;
    chk("clr_beats_inc", cnt_c, 0);

    // backpressure: out_ready low for 3 cycles, then release
    bp_vec[0] = 32'h00100093; bp_vec[1] = 32'h00200093;
    bp_vec[2] = 32'h00300093; bp_vec[3] = 32'h00400093;
    tx = 0; rx = 0; bubbles = 0;
    for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
      ifa.out_ready = (cyc >= 3);
      if (tx < 4) drv_a(1, bp_vec[tx], 32'h300 + 32'(tx));
      else        drv_a(0, 32'h0, 32'h0);
      in_f = ifa.in_valid && ifa.in_ready;
      if (ifa.out_valid && ifa.out_ready) begin
        chk("bp_order_tag", ifa.out_tag, 32'h300 + 32'(rx));
        chk("bp_order_imm", ifa.out_imm, 32'(rx + 1));
        rx++;
      end else if (rx > 0) begin
        bubbles++;
      end
      step();
      if (in_f) tx++;
      if (cyc == 2) begin
        chk("bp_accepted", 32'(tx), 2);
        chk("bp_in_ready_low", ifa.in_ready, 0);
        chk("bp_hold_tag", ifa.out_tag, 32'h300);
      end
    end
    chk("bp_received", 32'(rx), 4);
    chk("bp_sent", 32'(tx), 4);
    chk("bp_bubbles", 32'(bubbles), 0);
    drv_a(0, 32'h0, 32'h0);
    step();
    chk("bp_empty", ifa.out_valid, 0);

    // flush with both entries full
    ifa.out_ready = 1'b0;
    drv_a(1, 32'h00500093, 32'h400); step();
    drv_a(1, 32'h00600093, 32'h401); step();
    chk("fill_in_ready", ifa.in_ready, 0);
    flush = 1'b1;
    drv_a(1, 32'h00700093, 32'h402); step();
    flush = 1'b0;
    drv_a(0, 32'h0, 32'h0);
    chk("flush_valid", ifa.out_valid, 0);
    chk("flush_in_ready", ifa.in_ready, 1);
    step();
    chk("flush_dropped_input", ifa.out_valid, 0);

    // refill, then asynchronous reset in mid-cycle
    drv_a(1, 32'hFFF00093, 32'h5A5); step();
    drv_a(1, 32'h00800093, 32'h5A6); step();
    drv_a(0, 32'h0, 32'h0);
    chk("refill_tag", ifa.out_tag, 32'h5A5);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", ifa.out_valid, 0);
    chk("arst_imm", ifa.out_imm, 0);
    chk("arst_fmt", ifa.out_fmt, 0);
    chk("arst_tag", ifa.out_tag, 0);
    chk("arst_in_ready", ifa.in_ready, 1);
    chk("arst_count", cnt_a, 0);
    step();
    reset = 1'b0;
    step();
    chk("arst_skid_gone", ifa.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
